// File: rtl/ahb_req_sequencer_if.sv
// Requester, response and AHB bus bundle for ahb_req_sequencer.
// master is the sequencer's view, slave is the environment's view.
interface ahb_req_sequencer_if;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_write;
  logic [1:0]   req_wrap;
  logic [59:0]  req_addr;
  logic [7:0]   req_len;
  logic [511:0] req_wdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic         rsp_error;
  logic [255:0] rsp_rdata;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [2:0]   hburst;
  logic [31:0]  hwdata;
  logic [31:0]  hrdata;
  logic         hready;
  logic         hresp;

  modport master (
    input  req_valid, req_write, req_wrap,
    input  req_addr, req_len, req_wdata,
    output req_ready,
    output rsp_valid, rsp_id, rsp_error, rsp_rdata,
    input  rsp_ready,
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output req_valid, req_write, req_wrap,
    output req_addr, req_len, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_error, rsp_rdata,
    output rsp_ready,
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_req_sequencer.sv
// Two-requester round-robin front end issuing word bursts
// (up to 8 beats) on an AHB master port, one request at a time.
module ahb_req_sequencer (
  input  logic clk,
  input  logic rst_n,
  ahb_req_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_LAST,
    S_RESP
  } state_t;

  state_t state, state_nx;

  logic         prio;
  logic         gnt_any;
  logic         gnt_id;
  logic         sel_write;
  logic         sel_wrap;
  logic [3:0]   sel_len;
  logic [29:0]  sel_addr;
  logic [255:0] sel_wdata;
  logic         sel_ok;

  logic         id_q;
  logic         wr_q;
  logic         wrap_q;
  logic         err_q;
  logic         dvld_q;
  logic [3:0]   len_q;
  logic [3:0]   abeat_q;
  logic [2:0]   dbeat_q;
  logic [29:0]  addr_q;
  logic [255:0] wdata_q;
  logic [255:0] rdata_q;

  logic         last_a;
  logic         err_hit;
  logic [29:0]  waddr;
  logic [2:0]   burst;

  // round-robin pick and field select of the winning requester
  always_comb begin
    gnt_any = |bus.req_valid;
    gnt_id  = (&bus.req_valid) ? prio : bus.req_valid[1];
    if (gnt_id) begin
      sel_write = bus.req_write[1];
      sel_wrap  = bus.req_wrap[1];
      sel_len   = bus.req_len[7:4];
      sel_addr  = bus.req_addr[59:30];
      sel_wdata = bus.req_wdata[511:256];
    end else begin
      sel_write = bus.req_write[0];
      sel_wrap  = bus.req_wrap[0];
      sel_len   = bus.req_len[3:0];
      sel_addr  = bus.req_addr[29:0];
      sel_wdata = bus.req_wdata[255:0];
    end
    sel_ok = (sel_len != 4'd0) && (sel_len <= 4'd8);
  end

  // beat address: wrap only for 4/8-beat wrapping bursts
  always_comb begin
    waddr = addr_q + {26'd0, abeat_q};
    if (wrap_q && len_q == 4'd4) begin
      waddr = {addr_q[29:2], addr_q[1:0] + abeat_q[1:0]};
    end else if (wrap_q && len_q == 4'd8) begin
      waddr = {addr_q[29:3], addr_q[2:0] + abeat_q[2:0]};
    end
  end

  // hburst from latched length and wrap flag
  always_comb begin
    burst = 3'b000;
    case (len_q)
      4'd1:    burst = 3'b000;
      4'd4:    burst = wrap_q ? 3'b010 : 3'b011;
      4'd8:    burst = wrap_q ? 3'b100 : 3'b101;
      4'd2, 4'd3, 4'd5, 4'd6, 4'd7:
               burst = 3'b001;
      default: burst = 3'b000;
    endcase
  end

  assign last_a  = (abeat_q == len_q - 4'd1);
  assign err_hit = dvld_q && bus.hresp &&
                   (state == S_ADDR || state == S_LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (gnt_any) state_nx = sel_ok ? S_ADDR : S_RESP;
      end
      S_ADDR: begin
        if (err_hit) begin
          state_nx = bus.hready ? S_RESP : S_LAST;
        end else if (bus.hready && last_a) begin
          state_nx = S_LAST;
        end
      end
      S_LAST: begin
        if (bus.hready) state_nx = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // request latch, beat counters, read capture, error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      dvld_q  <= 1'b0;
      len_q   <= 4'd0;
      abeat_q <= 4'd0;
      dbeat_q <= 3'd0;
      addr_q  <= 30'd0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            prio    <= ~gnt_id;
            id_q    <= gnt_id;
            wr_q    <= sel_write;
            wrap_q  <= sel_wrap;
            len_q   <= sel_len;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            err_q   <= ~sel_ok;
            dvld_q  <= 1'b0;
            abeat_q <= 4'd0;
            dbeat_q <= 3'd0;
          end
        end
        S_ADDR: begin
          if (err_hit) begin
            err_q <= 1'b1;
          end else if (bus.hready) begin
            if (dvld_q && !wr_q)
              rdata_q[{dbeat_q, 5'd0} +: 32] <= bus.hrdata;
            dvld_q  <= 1'b1;
            dbeat_q <= abeat_q[2:0];
            abeat_q <= abeat_q + 4'd1;
          end
        end
        S_LAST: begin
          if (err_hit) begin
            err_q <= 1'b1;
          end else if (bus.hready && !wr_q) begin
            rdata_q[{dbeat_q, 5'd0} +: 32] <= bus.hrdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE && gnt_any && rst_n)
                       ? (2'b01 << gnt_id) : 2'b00;

  assign bus.htrans = (state != S_ADDR)  ? 2'b00 :
                      (abeat_q == 4'd0) ? 2'b10 : 2'b11;
  assign bus.haddr  = {waddr, 2'b00};
  assign bus.hwrite = wr_q;
  assign bus.hsize  = {1'b0, rst_n, 1'b0};
  assign bus.hburst = burst;
  assign bus.hwdata = wdata_q[{dbeat_q, 5'd0} +: 32];

  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_error = err_q;
  assign bus.rsp_rdata = rdata_q;

endmodule

// File: doc/ahb_req_sequencer.md
AHB_REQ_SEQUENCER -- requirements
Module: ahb_req_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 The block SHALL have no parameters; the maximum burst is 8 words, the address is 32 bits and every transfer is word-sized.
REQ-003 Ports SHALL be, as name, direction, width and meaning:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  request valid, one bit per requester (0, 1)
- req_ready  out  2  one-cycle accept pulse, one bit per requester
- req_write  in  2  1 = write, 0 = read
- req_wrap  in  2  1 = wrapping burst, 0 = incrementing burst
- req_addr  in  60  word address [31:2] per requester; requester i is at [i*30+:30]
- req_len  in  8  beat count per requester; legal values 1..8; requester i is at [i*4+:4]
- req_wdata  in  512  write data, 8 words per requester; requester i, beat k is at [i*256+k*32+:32]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  1  index of the requester being answered
- rsp_error  out  1  bus error or illegal length
- rsp_rdata  out  256  read words; beat k is at [k*32+:32]
- haddr  out  32  AHB address
- htrans  out  2  AHB transfer type: IDLE=00, NONSEQ=10, SEQ=11
- hwrite  out  1  AHB write
- hsize  out  3  AHB size, constant 3'b010
- hburst  out  3  AHB burst type
- hwdata  out  32  AHB write data
- hrdata  in  32  AHB read data
- hready  in  1  AHB ready
- hresp  in  1  AHB error response

Function
REQ-004 The block SHALL have four states: IDLE, ADDR (address phases being issued), LAST (data phase of the final beat only), RESP (response pending).
REQ-005 Arbitration SHALL be round-robin and SHALL occur only in IDLE.
- If both requesters are valid, the one not granted last SHALL win.
- After reset, requester 0 SHALL win a tie.
REQ-006 A grant SHALL pulse req_ready[i] for exactly one cycle, SHALL latch all fields of requester i, and SHALL move the block to ADDR on the next cycle.
REQ-007 If the latched req_len is 0 or greater than 8, the block SHALL issue no bus transfer and SHALL go directly to RESP with rsp_error=1.
REQ-008 hburst SHALL be chosen from the latched length and wrap flag:
- len 1: SINGLE (000)
- len 4: WRAP4 (010) if wrap, else INCR4 (011)
- len 8: WRAP8 (100) if wrap, else INCR8 (101)
- any other legal length: INCR (001), and req_wrap SHALL be ignored.
REQ-009 Beat 0 SHALL be driven with htrans=NONSEQ and later beats with htrans=SEQ; htrans SHALL be IDLE in every other state.
REQ-010 An address phase SHALL complete only on a cycle with hready=1.
- While hready=0, haddr, htrans, hwrite, hburst and hwdata SHALL hold their values.
REQ-011 The data phase of beat k SHALL be the cycle or cycles after its address phase completes, overlapping the address phase of beat k+1.
REQ-012 Address generation:
- Incrementing bursts SHALL add 4 per beat.
- Wrapping bursts SHALL keep haddr[31:n] fixed and increment haddr[n-1:0] modulo len*4 bytes (n=4 for WRAP4, n=5 for WRAP8).
REQ-013 During the data phase of beat k, hwdata SHALL equal word k of the latched write data.
REQ-014 On a read, hrdata SHALL be captured into rsp_rdata word k on the hready=1 cycle of data phase k; uncaptured words SHALL read 0.
REQ-015 When the last address phase completes, the block SHALL go to LAST; when the last data phase completes, it SHALL go to RESP.
REQ-016 On hresp=1 during any data phase:
- htrans SHALL be IDLE from the next cycle.
- No further beats SHALL be issued.
- On hready=1 the block SHALL go to RESP with rsp_error=1.
REQ-017 In RESP, rsp_valid, rsp_id, rsp_error and rsp_rdata SHALL be held until the cycle with rsp_ready=1; the block SHALL then return to IDLE.
REQ-018 Only one request SHALL be outstanding at a time: no grant until the response handshake completes.
REQ-019 A request may be granted at the earliest in the cycle after IDLE is re-entered.

Reset
REQ-020 While rst_n=0, all outputs SHALL be 0 (htrans=IDLE), the state SHALL be IDLE and the round-robin pointer SHALL favour requester 0.
REQ-021 Reset asserted mid-burst SHALL immediately force htrans=IDLE, SHALL drop the request and SHALL never produce a response for it.

Verification
REQ-022 INCR4 write, addr 0x100, hready=1 throughout:
- haddr 0x100/0x104/0x108/0x10C with htrans NONSEQ, SEQ, SEQ, SEQ and hburst=011.
- hwdata words 0..3, each one cycle later than its address.
- rsp_valid=1, rsp_error=0.
REQ-023 WRAP8 read, addr 0x118: haddr sequence 0x118, 0x11C, 0x100, 0x104, 0x108, 0x10C, 0x110, 0x114; rsp_rdata word k = hrdata of beat k.
REQ-024 Both requesters valid in back-to-back IDLEs: grants 0, 1, 0; rsp_id follows the same order.
REQ-025 hready=0 for 3 cycles during beat 2 of a 5-beat INCR: all bus outputs stable during the stall; hburst=001; total beats 5.
REQ-026 Illegal lengths and errors:
- req_len=0: no htrans≠IDLE, rsp_error=1.
- hresp=1 on beat 1 of 8: htrans IDLE next cycle, rsp_error=1, rsp_rdata words 1..7 = 0.
- rst_n low mid-burst: htrans=00 immediately and no response.
